// File: rtl/rob_queue.sv
// Reorder buffer: allocates in program order, accepts out-of-order CDB completions,
// retires the head in order and flushes everything when a mispredicted branch retires.
module rob_queue #(
  parameter int DEPTH     = 16,
  parameter int CDB_PORTS = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [2:0]                alloc_op_type,
  input  logic [4:0]                alloc_rd_addr,
  output logic [TAG_W-1:0]          alloc_tag,
  input  logic [CDB_PORTS-1:0]      cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]   cdb_data,
  input  logic [CDB_PORTS-1:0]      cdb_mispredict,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [TAG_W-1:0]          commit_tag,
  output logic [2:0]                commit_op_type,
  output logic [4:0]                commit_rd_addr,
  output logic [31:0]               commit_rd_data,
  output logic                      commit_regf_we,
  output logic                      flush,
  output logic [TAG_W:0]            count,
  output logic                      empty,
  output logic                      full
);

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     done_r;
  logic [DEPTH-1:0]     mispredict_r;
  logic [2:0]           op_type_r [DEPTH];
  logic [4:0]           rd_addr_r [DEPTH];
  logic [31:0]          rd_data_r [DEPTH];
  logic [TAG_W:0]       head_r;
  logic [TAG_W:0]       tail_r;

  logic [TAG_W-1:0]     head_idx_s;
  logic [TAG_W-1:0]     tail_idx_s;
  logic                 alloc_fire_s;
  logic                 commit_fire_s;
  logic [TAG_W-1:0]     cdb_idx_s [CDB_PORTS];
  logic [CDB_PORTS-1:0] cdb_hit_s;

  // Pointer advance; the extra MSB toggles naturally on wrap since DEPTH is a power of two.
  function automatic logic [TAG_W:0] ptr_inc(input logic [TAG_W:0] p);
    return p + {{TAG_W{1'b0}}, 1'b1};
  endfunction

  assign head_idx_s     = head_r[TAG_W-1:0];
  assign tail_idx_s     = tail_r[TAG_W-1:0];
  assign full           = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
  assign empty          = (head_r == tail_r);
  assign count          = tail_r - head_r;
  assign alloc_ready    = !full && !flush;
  assign alloc_tag      = tail_idx_s;
  assign alloc_fire_s   = alloc_valid && alloc_ready;

  assign commit_valid   = valid_r[head_idx_s] && done_r[head_idx_s];
  assign commit_fire_s  = commit_valid && commit_ready;
  assign flush          = commit_fire_s && mispredict_r[head_idx_s];
  assign commit_tag     = head_idx_s;
  assign commit_op_type = commit_valid ? op_type_r[head_idx_s] : 3'd0;
  assign commit_rd_addr = commit_valid ? rd_addr_r[head_idx_s] : 5'd0;
  assign commit_rd_data = commit_valid ? rd_data_r[head_idx_s] : 32'd0;
  assign commit_regf_we = commit_valid && (commit_rd_addr != 5'd0);

  // Decode which CDB channels hit an allocated entry still waiting for its result.
  always_comb begin
    for (int i = 0; i < CDB_PORTS; i++) begin
      cdb_idx_s[i] = cdb_tag[i*TAG_W +: TAG_W];
      cdb_hit_s[i] = cdb_valid[i] && valid_r[cdb_idx_s[i]] && !done_r[cdb_idx_s[i]];
    end
  end

  // Entry storage and pointer update: reset, flush, completion, allocate, commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r       <= '0;
      tail_r       <= '0;
      valid_r      <= '0;
      done_r       <= '0;
      mispredict_r <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        op_type_r[e] <= 3'd0;
        rd_addr_r[e] <= 5'd0;
        rd_data_r[e] <= 32'd0;
      end
    end else if (flush) begin
      head_r       <= '0;
      tail_r       <= '0;
      valid_r      <= '0;
      done_r       <= '0;
      mispredict_r <= '0;
    end else begin
      // Highest channel first so the lowest-numbered channel's write lands last and wins.
      for (int i = CDB_PORTS - 1; i >= 0; i--) begin
        if (cdb_hit_s[i]) begin
          done_r[cdb_idx_s[i]]       <= 1'b1;
          rd_data_r[cdb_idx_s[i]]    <= cdb_data[i*32 +: 32];
          mispredict_r[cdb_idx_s[i]] <= cdb_mispredict[i];
        end
      end
      if (alloc_fire_s) begin
        valid_r[tail_idx_s]      <= 1'b1;
        done_r[tail_idx_s]       <= 1'b0;
        mispredict_r[tail_idx_s] <= 1'b0;
        op_type_r[tail_idx_s]    <= alloc_op_type;
        rd_addr_r[tail_idx_s]    <= alloc_rd_addr;
        rd_data_r[tail_idx_s]    <= 32'd0;
        tail_r                   <= ptr_inc(tail_r);
      end
      if (commit_fire_s) begin
        valid_r[head_idx_s] <= 1'b0;
        head_r              <= ptr_inc(head_r);
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue: a scoreboard of allocated entries checked at commit,
// plus directed checks of occupancy, flush and handshake behaviour.
module tb_rob_queue;
  localparam logic [2:0] OP_INT = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_op_type;
  logic [4:0]  alloc_rd_addr;
  logic [3:0]  alloc_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [1:0]  cdb_mispredict;
  logic        commit_valid;
  logic        commit_ready;
  logic [3:0]  commit_tag;
  logic [2:0]  commit_op_type;
  logic [4:0]  commit_rd_addr;
  logic [31:0] commit_rd_data;
  logic        commit_regf_we;
  logic        flush;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] tag;
    logic [2:0] op;
    logic [4:0] rd;
  } exp_t;
  exp_t sb_q[$];

  logic        ref_valid [16];
  logic        ref_done  [16];
  logic        ref_mis   [16];
  logic [31:0] ref_data  [16];

  rob_queue #(.DEPTH(16), .CDB_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op_type(alloc_op_type), .alloc_rd_addr(alloc_rd_addr), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_op_type(commit_op_type), .commit_rd_addr(commit_rd_addr),
    .commit_rd_data(commit_rd_data), .commit_regf_we(commit_regf_we),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_op_type  = 3'd0;
    alloc_rd_addr  = 5'd0;
    cdb_valid      = 2'b00;
    cdb_tag        = 8'd0;
    cdb_data       = 64'd0;
    cdb_mispredict = 2'b00;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    commit_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    for (int e = 0; e < 16; e++) begin
      ref_valid[e] = 1'b0;
      ref_done[e]  = 1'b0;
      ref_mis[e]   = 1'b0;
      ref_data[e]  = 32'd0;
    end
    #1;
    check("reset_count", count, 32'd0);
    check("reset_empty", empty, 32'd1);
    check("reset_commit_valid", commit_valid, 32'd0);
  endtask

  task automatic do_alloc(input logic [2:0] op, input logic [4:0] rd);
    check("alloc_ready", alloc_ready, 32'd1);
    if (alloc_ready) begin
      sb_q.push_back('{tag: alloc_tag, op: op, rd: rd});
      ref_valid[alloc_tag] = 1'b1;
      ref_done[alloc_tag]  = 1'b0;
      ref_mis[alloc_tag]   = 1'b0;
      ref_data[alloc_tag]  = 32'd0;
    end
    alloc_valid   = 1'b1;
    alloc_op_type = op;
    alloc_rd_addr = rd;
    cycle();
  endtask

  task automatic model_cdb(input logic v, input logic [3:0] t, input logic [31:0] d, input logic m);
    if (v && ref_valid[t] && !ref_done[t]) begin
      ref_done[t] = 1'b1;
      ref_data[t] = d;
      ref_mis[t]  = m;
    end
  endtask

  task automatic cdb2(input logic v0, input logic [3:0] t0, input logic [31:0] d0, input logic m0,
                      input logic v1, input logic [3:0] t1, input logic [31:0] d1, input logic m1);
    cdb_valid      = {v1, v0};
    cdb_tag        = {t1, t0};
    cdb_data       = {d1, d0};
    cdb_mispredict = {m1, m0};
    model_cdb(v0, t0, d0, m0);
    model_cdb(v1, t1, d1, m1);
    cycle();
  endtask

  // Scoreboard: every retirement is matched against the oldest allocated entry.
  always @(negedge clk) begin
    if (rst_n && commit_valid && commit_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("commit_tag", commit_tag, e.tag);
        check("commit_op", commit_op_type, e.op);
        check("commit_rd", commit_rd_addr, e.rd);
        check("commit_data", commit_rd_data, ref_data[e.tag]);
        check("commit_we", commit_regf_we, (e.rd != 5'd0) ? 32'd1 : 32'd0);
        check("commit_flush", flush, ref_mis[e.tag]);
        ref_valid[e.tag] = 1'b0;
        if (flush) begin
          sb_q.delete();
          for (int e2 = 0; e2 < 16; e2++) ref_valid[e2] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check("rst_full", full, 32'd0);
    check("rst_alloc_ready", alloc_ready, 32'd1);
    check("rst_alloc_tag", alloc_tag, 32'd0);
    check("rst_regf_we", commit_regf_we, 32'd0);
    check("rst_flush", flush, 32'd0);
    check("rst_commit_data", commit_rd_data, 32'd0);

    // Fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      check("fill_tag", alloc_tag, i);
      do_alloc(OP_INT, 5'(i + 1));
    end
    check("fill_full", full, 32'd1);
    check("fill_alloc_ready", alloc_ready, 32'd0);
    check("fill_count", count, 32'd16);

    // Head done but consumer stalled: outputs hold
    cdb2(1'b1, 4'd0, 32'h55, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", commit_valid, 32'd1);
      check("stall_tag", commit_tag, 32'd0);
      check("stall_rd", commit_rd_addr, 32'd1);
      check("stall_data", commit_rd_data, 32'h55);
      cycle();
    end
    // Full and committing: no same-cycle bypass for allocation
    commit_ready  = 1'b1;
    alloc_valid   = 1'b1;
    alloc_op_type = OP_INT;
    alloc_rd_addr = 5'd20;
    #1;
    check("full_commit_alloc_ready", alloc_ready, 32'd0);
    cycle();
    check("after_commit_alloc_ready", alloc_ready, 32'd1);
    check("after_commit_count", count, 32'd15);
    check("after_commit_valid", commit_valid, 32'd0);
    commit_ready = 1'b0;

    // Out-of-order completion, in-order retirement
    do_reset();
    commit_ready = 1'b1;
    do_alloc(OP_INT, 5'd1);
    do_alloc(OP_INT, 5'd2);
    do_alloc(OP_INT, 5'd3);
    cdb2(1'b1, 4'd2, 32'hC, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("ooo_wait_head", commit_valid, 32'd0);
    cdb2(1'b1, 4'd0, 32'hA, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("ooo_c0_valid", commit_valid, 32'd1);
    check("ooo_c0_data", commit_rd_data, 32'hA);
    check("ooo_c0_we", commit_regf_we, 32'd1);
    cdb2(1'b1, 4'd1, 32'hB, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("ooo_c1_data", commit_rd_data, 32'hB);
    check("ooo_c1_tag", commit_tag, 32'd1);
    cycle();
    check("ooo_c2_data", commit_rd_data, 32'hC);
    cycle();
    check("ooo_empty", empty, 32'd1);

    // Same-tag collision and dual completion
    do_reset();
    for (int i = 0; i < 6; i++) do_alloc(OP_INT, 5'(i + 4));
    cdb2(1'b1, 4'd3, 32'h11, 1'b0, 1'b1, 4'd3, 32'h22, 1'b0);
    cdb2(1'b1, 4'd4, 32'h44, 1'b0, 1'b1, 4'd5, 32'h55, 1'b0);
    cdb2(1'b1, 4'd3, 32'h33, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cdb2(1'b1, 4'(i), 32'h100 + i, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    commit_ready = 1'b1;
    for (int k = 0; k < 20 && !empty; k++) cycle();
    check("dual_drained", empty, 32'd1);
    check("dual_sb_left", sb_q.size(), 32'd0);
    commit_ready = 1'b0;

    // Wrap-around with continuous retirement
    do_reset();
    commit_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("wrap_tag", alloc_tag, i % 16);
      do_alloc(OP_INT, 5'((i % 31) + 1));
      check("wrap_count1", count, 32'd1);
      cdb2(1'b1, 4'(i % 16), 32'(i * 3 + 7), 1'b0, 1'b1, 4'((i + 5) % 16), 32'hDEAD, 1'b0);
      check("wrap_valid", commit_valid, 32'd1);
      cycle();
      check("wrap_count0", count, 32'd0);
    end
    commit_ready = 1'b0;

    // Mispredicted branch flush
    do_reset();
    do_alloc(OP_BR, 5'd0);
    for (int i = 0; i < 3; i++) do_alloc(OP_INT, 5'(i + 7));
    cdb2(1'b1, 4'd0, 32'h77, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    check("br_valid", commit_valid, 32'd1);
    check("br_no_flush_stalled", flush, 32'd0);
    commit_ready  = 1'b1;
    alloc_valid   = 1'b1;
    alloc_op_type = OP_INT;
    alloc_rd_addr = 5'd9;
    #1;
    check("br_flush", flush, 32'd1);
    check("br_flush_alloc_ready", alloc_ready, 32'd0);
    check("br_regf_we", commit_regf_we, 32'd0);
    cycle();
    commit_ready = 1'b0;
    check("flush_count", count, 32'd0);
    check("flush_empty", empty, 32'd1);
    check("flush_alloc_tag", alloc_tag, 32'd0);
    cdb2(1'b1, 4'd0, 32'h99, 1'b0, 1'b1, 4'd1, 32'h98, 1'b0);
    check("flush_stale_cdb", commit_valid, 32'd0);
    check("final_sb_left", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
